// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 1-to-3 demultiplexer slice.
//   SEL_CH0..SEL_SPECIAL : destination select encodings on in_sel
//   NUM_CH               : number of output channels (3)
//   state_t              : occupancy state of the output register
//   state_of()           : classifies a pending mask as EMPTY/SINGLE/BCAST
// Configuration macro: DEMUX_BCAST_EN (consumed by demux_sel_decode).
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int NUM_CH = 3;

    localparam logic [1:0] SEL_CH0     = 2'b00;
    localparam logic [1:0] SEL_CH1     = 2'b01;
    localparam logic [1:0] SEL_CH2     = 2'b10;
    localparam logic [1:0] SEL_SPECIAL = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SINGLE = 2'd1,
        ST_BCAST  = 2'd2
    } state_t;

    function automatic state_t state_of(input logic [NUM_CH-1:0] mask);
        int n;
        n = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + int'(mask[i]);
        end
        if (n == 0) begin
            return ST_EMPTY;
        end else if (n == 1) begin
            return ST_SINGLE;
        end
        return ST_BCAST;
    endfunction

endpackage

// File: rtl/demuxer_1_to_3_if.sv
// -----------------------------------------------------------------------------
// demuxer_1_to_3_if
// Handshake bundle between a word source, the demultiplexer and three sinks.
//   in_data/in_sel/in_valid : source word, destination select, valid
//   in_ready                : demux accepts the word this cycle
//   out_data                : registered word shared by all channels
//   out_valid/out_ready     : per-channel handshake, bit n = channel n
//   drop                    : one-cycle pulse when a word is discarded
// Modports: master (source + sinks side), slave (demultiplexer side).
// -----------------------------------------------------------------------------
interface demuxer_1_to_3_if #(
    parameter int SIZE = 16
);
    logic [SIZE-1:0]                in_data;
    logic [1:0]                     in_sel;
    logic                           in_valid;
    logic                           in_ready;
    logic [SIZE-1:0]                out_data;
    logic [demux_pkg::NUM_CH-1:0]   out_valid;
    logic [demux_pkg::NUM_CH-1:0]   out_ready;
    logic                           drop;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop
    );
endinterface

// File: rtl/demux_sel_decode.sv
// -----------------------------------------------------------------------------
// demux_sel_decode
// Combinational decode of the 2-bit destination select into a channel mask.
//   sel  : in_sel encoding (00=ch0, 01=ch1, 10=ch2, 11=special)
//   mask : one bit per channel that should receive the word
// Configuration macro: DEMUX_BCAST_EN
//   defined   -> special select broadcasts to all channels (111)
//   undefined -> special select decodes to 000, which the top treats as a drop
// -----------------------------------------------------------------------------
module demux_sel_decode
    import demux_pkg::*;
(
    input  logic [1:0]        sel,
    output logic [NUM_CH-1:0] mask
);

    always_comb begin
        mask = '0;
        case (sel)
            SEL_CH0:     mask = 3'b001;
            SEL_CH1:     mask = 3'b010;
            SEL_CH2:     mask = 3'b100;
            SEL_SPECIAL: begin
`ifdef DEMUX_BCAST_EN
                mask = 3'b111;
`else
                mask = 3'b000;
`endif
            end
            default:     mask = '0;
        endcase
    end

endmodule

// File: rtl/demuxer_1_to_3.sv
// -----------------------------------------------------------------------------
// demuxer_1_to_3
// One-word-deep demultiplexer: a source word is captured into a data register
// and presented to one channel (or all three when broadcasting) until each
// addressed channel has taken it.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : demuxer_1_to_3_if.slave (in_* from source, out_* to sinks, drop)
// Configuration macro: DEMUX_BCAST_EN (select 11 = broadcast when defined,
// otherwise select 11 is accepted and discarded with a drop pulse).
// -----------------------------------------------------------------------------
module demuxer_1_to_3
    import demux_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    demuxer_1_to_3_if.slave  bus
);

    logic [SIZE-1:0]   data_reg;
    logic [NUM_CH-1:0] pending_reg;
    logic [NUM_CH-1:0] pending_next;
    logic [NUM_CH-1:0] stall;
    logic [NUM_CH-1:0] sel_mask;
    logic              drop_reg;
    logic              ready;
    logic              accept;
    state_t            state_reg;

    demux_sel_decode u_sel_decode (
        .sel  (bus.in_sel),
        .mask (sel_mask)
    );

    // A channel stalls when it still holds the word and its sink is not taking it.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_stall
        assign stall[gi] = pending_reg[gi] & ~bus.out_ready[gi];
    end

    // Ready when the register is empty or every remaining holder drains now,
    // which lets a new word follow the last transfer without a bubble.
    assign ready        = (state_reg == ST_EMPTY) || (stall == '0);
    assign accept       = bus.in_valid && ready;
    assign pending_next = pending_reg & ~bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg    <= '0;
            pending_reg <= '0;
            drop_reg    <= 1'b0;
            state_reg   <= ST_EMPTY;
        end else if (accept && (sel_mask != '0)) begin
            data_reg    <= bus.in_data;
            pending_reg <= sel_mask;
            drop_reg    <= 1'b0;
            state_reg   <= state_of(sel_mask);
        end else begin
            // An accepted word with an empty mask is the discarded special
            // select: the register keeps its contents and only drop pulses.
            pending_reg <= pending_next;
            drop_reg    <= accept;
            state_reg   <= state_of(pending_next);
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_reg;
    assign bus.out_valid = pending_reg;
    assign bus.drop      = drop_reg;

endmodule

// File: tb/tb_demuxer_1_to_3.sv
// -----------------------------------------------------------------------------
// tb_demuxer_1_to_3
// Directed and short random stimulus for demuxer_1_to_3 with a reference
// model of the pending mask / data register and a scoreboard queue of words
// expected on each channel. Build with or without DEMUX_BCAST_EN.
// -----------------------------------------------------------------------------
module tb_demuxer_1_to_3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    demuxer_1_to_3_if #(.SIZE(16)) bus ();

    demuxer_1_to_3 #(.SIZE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          ch;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [2:0]  mdl_pending = 3'b000;
    logic [15:0] mdl_data = 16'h0000;
    logic        mdl_drop = 1'b0;

    function automatic logic [2:0] tb_decode(input logic [1:0] s);
        case (s)
            2'b00:   return 3'b001;
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
`ifdef DEMUX_BCAST_EN
            default: return 3'b111;
`else
            default: return 3'b000;
`endif
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: compare DUT against the model with the inputs already
    // applied, score any channel transfers, advance the model, then wait for
    // the next falling edge.
    task automatic tick();
        logic       mdl_ready;
        logic       acc;
        logic [2:0] m;
        int         found;
        #1;
        mdl_ready = ((mdl_pending & ~bus.out_ready) == 3'b000);
        check("out_valid", 32'(bus.out_valid), 32'(mdl_pending));
        check("in_ready",  32'(bus.in_ready),  32'(mdl_ready));
        check("out_data",  32'(bus.out_data),  32'(mdl_data));
        check("drop",      32'(bus.drop),      32'(mdl_drop));

        for (int n = 0; n < 3; n++) begin
            if (bus.out_valid[n] && bus.out_ready[n]) begin
                found = -1;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (found < 0 && exp_q[i].ch == n) found = i;
                end
                check("sb_expected", 32'(found >= 0), 32'd1);
                if (found >= 0) begin
                    check("sb_data", 32'(bus.out_data), 32'(exp_q[found].data));
                    $display("xfer ch%0d data %h", n, bus.out_data);
                    exp_q.delete(found);
                end
            end
        end

        acc = bus.in_valid && mdl_ready;
        if (rst) begin
            mdl_pending = 3'b000;
            mdl_data    = 16'h0000;
            mdl_drop    = 1'b0;
            exp_q.delete();
        end else if (acc) begin
            m = tb_decode(bus.in_sel);
            if (m != 3'b000) begin
                mdl_pending = m;
                mdl_data    = bus.in_data;
                mdl_drop    = 1'b0;
                for (int n = 0; n < 3; n++) begin
                    if (m[n]) exp_q.push_back('{ch: n, data: bus.in_data});
                end
            end else begin
                mdl_pending = mdl_pending & ~bus.out_ready;
                mdl_drop    = 1'b1;
            end
        end else begin
            mdl_pending = mdl_pending & ~bus.out_ready;
            mdl_drop    = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] prev;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 3'b000;

        // Reset
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_drop",      32'(bus.drop),      32'd0);

        // Single word to ch1, sink ready
        bus.in_sel = 2'b01; bus.in_data = 16'hA5A5; bus.in_valid = 1'b1;
        bus.out_ready = 3'b111;
        tick();
        bus.in_valid = 1'b0;
        check("ch1_valid", 32'(bus.out_valid), 32'h2);
        check("ch1_data",  32'(bus.out_data),  32'hA5A5);
        tick();
        check("ch1_cleared", 32'(bus.out_valid), 32'h0);

        // Backpressure on ch0
        bus.in_sel = 2'b00; bus.in_data = 16'h1234; bus.in_valid = 1'b1;
        bus.out_ready = 3'b000;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp_valid", 32'(bus.out_valid), 32'h1);
            check("bp_ready", 32'(bus.in_ready),  32'h0);
            check("bp_data",  32'(bus.out_data),  32'h1234);
            tick();
        end
        bus.out_ready = 3'b001;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'h1);
        tick();

        // Back-to-back words to ch2
        bus.out_ready = 3'b100;
        for (int w = 1; w <= 3; w++) begin
            bus.in_sel = 2'b10; bus.in_data = 16'(w); bus.in_valid = 1'b1;
            #1;
            check("b2b_ready", 32'(bus.in_ready), 32'h1);
            if (w > 1) begin
                check("b2b_valid", 32'(bus.out_valid), 32'h4);
                check("b2b_data",  32'(bus.out_data),  32'(w - 1));
            end
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();

        // Input held off while busy: state unchanged, no drop
        bus.in_sel = 2'b01; bus.in_data = 16'h5555; bus.in_valid = 1'b1;
        bus.out_ready = 3'b000;
        tick();
        bus.in_sel = 2'b00; bus.in_data = 16'h6666;
        tick();
        check("hold_valid", 32'(bus.out_valid), 32'h2);
        check("hold_data",  32'(bus.out_data),  32'h5555);
        check("hold_drop",  32'(bus.drop),      32'h0);
        bus.in_valid = 1'b0; bus.out_ready = 3'b010;
        tick();
        bus.out_ready = 3'b000;

`ifdef DEMUX_BCAST_EN
        // Broadcast with sinks served one at a time
        bus.in_sel = 2'b11; bus.in_data = 16'hBEEF; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 3'b001; #1;
        check("bc_valid0", 32'(bus.out_valid), 32'h7);
        check("bc_ready0", 32'(bus.in_ready),  32'h0);
        tick();
        bus.out_ready = 3'b100; #1;
        check("bc_valid1", 32'(bus.out_valid), 32'h6);
        check("bc_ready1", 32'(bus.in_ready),  32'h0);
        tick();
        bus.out_ready = 3'b010; #1;
        check("bc_valid2", 32'(bus.out_valid), 32'h2);
        check("bc_ready2", 32'(bus.in_ready),  32'h1);
        tick();
        bus.out_ready = 3'b000;
        check("bc_valid3", 32'(bus.out_valid), 32'h0);
`else
        // Special select discarded
        prev = mdl_data;
        bus.in_sel = 2'b11; bus.in_data = 16'hDEAD; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("drop_pulse", 32'(bus.drop),      32'h1);
        check("drop_valid", 32'(bus.out_valid), 32'h0);
        check("drop_data",  32'(bus.out_data),  32'(prev));
        tick();
        check("drop_end",   32'(bus.drop),      32'h0);
`endif

        // Reset with a ch1 word pending
        bus.in_sel = 2'b01; bus.in_data = 16'h7777; bus.in_valid = 1'b1;
        bus.out_ready = 3'b000;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_data",  32'(bus.out_data),  32'h0);
        check("mid_rst_ready", 32'(bus.in_ready),  32'h1);
        bus.out_ready = 3'b111;
        tick();
        tick();

        // Accept attempted while reset is high is ignored
        rst = 1'b1;
        bus.in_sel = 2'b00; bus.in_data = 16'h9999; bus.in_valid = 1'b1;
        tick();
        rst = 1'b0; bus.in_valid = 1'b0;
        check("rst_accept_valid", 32'(bus.out_valid), 32'h0);
        tick();

        // Short random traffic against the model
        for (int c = 0; c < 200; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_sel    = 2'($urandom_range(0, 3));
            bus.in_data   = 16'($urandom);
            bus.out_ready = 3'($urandom_range(0, 7));
            tick();
        end

        // Drain and confirm nothing is left undelivered
        bus.in_valid  = 1'b0;
        bus.out_ready = 3'b111;
        tick();
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demuxer_1_to_3.md
DEMUXER_1_TO_3 -- requirements
Module: demuxer_1_to_3

Interface
REQ-001 The block SHALL have parameter: SIZE, 16, data width in bits.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port: in_data  input  SIZE  source word.
REQ-005 The block SHALL have port: in_sel  input  2  destination select; 00=ch0, 01=ch1, 10=ch2, 11=special.
REQ-006 The block SHALL have port: in_valid  input  1  source word and select valid.
REQ-007 The block SHALL have port: in_ready  output  1  block accepts word this cycle.
REQ-008 The block SHALL have port: out_data  output  SIZE  registered word, shared by all channels.
REQ-009 The block SHALL have port: out_valid  output  3  per-channel valid, bit n = channel n.
REQ-010 The block SHALL have port: out_ready  input  3  per-channel ready, bit n = channel n.
REQ-011 The block SHALL have port: drop  output  1  one-cycle pulse when a word is discarded.

Function
REQ-012 Internal state SHALL be a data register and a 3-bit pending mask; out_data = data register and out_valid = pending mask.
REQ-013 A transfer on channel n SHALL occur in a cycle with out_valid[n] && out_ready[n]; pending bit n clears on the next edge.
REQ-014 in_ready SHALL be combinational: 1 when (pending & ~out_ready) == 0, i.e. the register is empty or every pending channel transfers this cycle.
REQ-015 On in_valid && in_ready, the block SHALL load in_data and set pending to the decoded select mask (00->001, 01->010, 10->100); latency input-to-out_valid is 1 cycle.
REQ-016 With in_valid && in_ready and the last pending channels transferring in the same cycle, the block SHALL load the new word without a bubble (full throughput of 1 word/cycle per channel).
REQ-017 When not accepting, the block SHALL update pending to pending & ~out_ready and hold the data register.
REQ-018 out_valid[n] SHALL NOT drop before its transfer, and out_data SHALL be stable while any pending bit is set.
REQ-019 The state SHALL be EMPTY (pending=000), SINGLE (one bit set) or BCAST (more than one bit set); EMPTY->SINGLE/BCAST on accept; SINGLE/BCAST->EMPTY when the last pending bit transfers with no new accept.
REQ-020 In BCAST, each channel SHALL transfer independently; a channel already served SHALL have out_valid low while the others are pending.
REQ-021 in_valid with in_ready low SHALL leave all state unchanged and SHALL NOT raise drop.

Reset
REQ-022 When rst is high at an edge, pending SHALL be 000, the data register 0 and drop 0; out_valid = 000 on the following cycle.
REQ-023 Reset mid-transfer SHALL discard the pending word and any partial broadcast; in_ready SHALL be 1 in the first cycle after reset.
REQ-024 An accept in the same cycle as rst high SHALL be ignored.

Configuration
REQ-025 Macro DEMUX_BCAST_EN SHALL control the handling of in_sel=11.
REQ-026 With DEMUX_BCAST_EN defined, in_sel=11 SHALL decode to 111, a broadcast to all three channels.
REQ-027 Without DEMUX_BCAST_EN, in_sel=11 SHALL be accepted when in_ready is 1, SHALL leave pending and data unchanged, and SHALL pulse drop for one cycle on the next edge; the BCAST state is unreachable.

Structure
REQ-028 Shared package demux_pkg SHALL hold the select encodings (SEL_CH0=00, SEL_CH1=01, SEL_CH2=10, SEL_SPECIAL=11) and the channel-count constant 3.
REQ-029 The select-to-mask decode SHALL be a combinational sub-module demux_sel_decode (in_sel -> 3-bit mask, macro-aware); the data register, pending mask and handshake logic SHALL stay in demuxer_1_to_3.

Verification
REQ-030 Reset, then in_sel=01 with in_data=16'hA5A5 and out_ready=111 -> out_valid=010 and out_data=A5A5 one cycle later, then 000 on the next cycle.
REQ-031 in_sel=00 with data 16'h1234 and out_ready=000 for 3 cycles -> out_valid=001 held, in_ready=0 and data stable; out_ready=001 -> in_ready=1 in the same cycle.
REQ-032 Back-to-back words 1,2,3 to ch2 with out_ready=100 continuous -> one word per cycle, in_ready constantly 1, order preserved.
REQ-033 DEMUX_BCAST_EN defined, in_sel=11 with data 16'hBEEF, out_ready toggled 001, 100, 010 in turn -> out_valid sequence 111, 110, 010, 000 and in_ready high only in the 010 cycle.
REQ-034 DEMUX_BCAST_EN undefined, in_sel=11 with data 16'hDEAD -> drop=1 for exactly one cycle, out_valid stays 000 and out_data unchanged.
REQ-035 Pending ch1 word with rst asserted for one cycle -> out_valid=000, out_data=0 and in_ready=1 afterward; the stale word is never delivered.
